alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Control stage directly upstream of the ALU; sequences one register-register ALU instruction over the shared bus.
- Latches opcode and register fields on start, then steps T3..T6: drives register select/out strobes, Yin/Zin, exactly one one-hot ALU op line, and the Z/LO/HI capture strobes.
- Holds the op line for a programmable settle window on MUL/DIV, which are 64-bit and written back through LO/HI.

Parameters:
- MULDIV_WAIT, 2, extra cycles op line and Zin are held after T4 for MUL/DIV (0..15)

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous active-low reset
- start  in  1  request to execute latched fields; accepted only in IDLE
- opcode  in  5  instruction opcode
- ra  in  4  destination register index
- rb  in  4  first source register index
- rc  in  4  second source register index
- reg_sel  out  4  register index currently addressed on bus
- Rout  out  1  selected register drives bus
- Rin  out  1  selected register captures bus
- Yin  out  1  Y register captures bus
- Zin  out  1  Z (resultHi:resultLo) captures ALU output
- ZLoout  out  1  Z low drives bus
- ZHiout  out  1  Z high drives bus
- LOin  out  1  LO register captures bus
- HIin  out  1  HI register captures bus
- AND, OR, NEG, NOT, MUL, ROL, ROR, DIV  out  1 each  one-hot ALU op select
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion
- err  out  1  one-cycle pulse on illegal opcode

Behaviour:
- All outputs registered (Moore). Async reset (clr=0): state IDLE, every output 0, latched fields 0. Reset mid-instruction aborts immediately; no further strobes.
- Opcode map: 08 AND, 09 OR, 0A ROR, 0B ROL, 0E MUL, 0F DIV, 10 NEG, 11 NOT; anything else illegal.
- IDLE: start=1 latches opcode/ra/rb/rc; next state T3 if legal, ERR otherwise. start while busy ignored, fields not re-latched.
- T3: reg_sel=rb, Rout=1, Yin=1. Unary NEG/NOT also pass through T3 (Y loaded, unused).
- T4: reg_sel=rc for binary ops, rb for NEG/NOT; Rout=1; decoded op line=1; Zin=1. Next: WAIT if MUL/DIV and MULDIV_WAIT>0, else T5.
- WAIT: Rout, reg_sel, op line and Zin held; counter runs MULDIV_WAIT cycles, then T5. Counter cleared on entry.
- T5: ZLoout=1. Non-MUL/DIV: reg_sel=ra, Rin=1, next DONE. MUL/DIV: LOin=1, next T6.
- T6 (MUL/DIV only): ZHiout=1, HIin=1, next DONE.
- DONE: done=1, busy=1 for this cycle, next IDLE. start is accepted only in IDLE, one cycle later.
- ERR: err=1, no Rin/LOin/HIin/Zin, next IDLE.
- Invariants: at most one op line high in any cycle; op lines low outside T4/WAIT; Rout, ZLoout and ZHiout never high together; Rin, LOin and HIin mutually exclusive.
- Latency from start cycle to done: 4 cycles (logic/rotate/unary), 5+MULDIV_WAIT cycles (MUL/DIV).

Test Plan:
- Reset: clr low mid-T4 of AND → all outputs 0 asynchronously; after release, state IDLE, busy=0.
- AND: opcode=08, ra=3, rb=1, rc=2 → T3 reg_sel=1 Rout Yin; T4 reg_sel=2 AND Zin; T5 reg_sel=3 ZLoout Rin; done 4 cycles after start.
- MUL, MULDIV_WAIT=2: opcode=0E → MUL and Zin held 3 cycles (T4 plus 2 WAIT); LOin then HIin; done 7 cycles after start; Rin never asserted.
- NEG: opcode=10, rb=5, ra=6 → T4 reg_sel=5 with NEG; writeback to reg 6; only NEG asserted among op lines.
- Illegal opcode=1F → err pulse next cycle, no write strobes, busy drops; following start with opcode=09 runs OR normally.
- start pulsed every cycle during a DIV → only the first is accepted; latched fields unchanged; no overlap; exactly one done.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Bus between the instruction issuer and the ALU control sequencer.
// The issuer (master) drives start and the fields; the sequencer (slave) drives the strobes.
interface alu_sequencer_if;
    logic       start;
    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;

    logic [3:0] reg_sel;
    logic       Rout;
    logic       Rin;
    logic       Yin;
    logic       Zin;
    logic       ZLoout;
    logic       ZHiout;
    logic       LOin;
    logic       HIin;

    logic       AND;
    logic       OR;
    logic       NEG;
    logic       NOT;
    logic       MUL;
    logic       ROL;
    logic       ROR;
    logic       DIV;

    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, opcode, ra, rb, rc,
        input  reg_sel, Rout, Rin, Yin, Zin, ZLoout, ZHiout, LOin, HIin,
        input  AND, OR, NEG, NOT, MUL, ROL, ROR, DIV,
        input  busy, done, err
    );

    modport slave (
        input  start, opcode, ra, rb, rc,
        output reg_sel, Rout, Rin, Yin, Zin, ZLoout, ZHiout, LOin, HIin,
        output AND, OR, NEG, NOT, MUL, ROL, ROR, DIV,
        output busy, done, err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Control sequencer for one register-register ALU instruction (T3..T6).
// Outputs are registered from the next state so they line up with the state.
module alu_sequencer #(
    parameter int unsigned MULDIV_WAIT = 2
) (
    input logic           clk,
    input logic           clr,
    alu_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_T3, S_T4, S_WAIT, S_T5, S_T6, S_DONE, S_ERR
    } state_t;

    typedef struct packed {
        logic [3:0] sel;
        logic       rout;
        logic       rin;
        logic       yin;
        logic       zin;
        logic       zlo;
        logic       zhi;
        logic       loin;
        logic       hiin;
        logic [7:0] op;
        logic       busy;
        logic       done;
        logic       err;
    } out_t;

    state_t     state_q, state_d;
    logic [4:0] opc_q, opc_d;
    logic [3:0] ra_q, ra_d;
    logic [3:0] rb_q, rb_d;
    logic [3:0] rc_q, rc_d;
    logic [3:0] cnt_q, cnt_d;
    out_t       out_q, out_d;

    logic [7:0] opv;
    logic       muldiv;
    logic       unary;
    logic       wait_last;
    logic       accept;

    // Op vector bit order: AND OR NEG NOT MUL ROL ROR DIV (msb first)
    function automatic logic [7:0] decode(input logic [4:0] opc);
        logic [7:0] v;
        v = '0;
        case (opc)
            5'h08:   v = 8'h80;
            5'h09:   v = 8'h40;
            5'h10:   v = 8'h20;
            5'h11:   v = 8'h10;
            5'h0E:   v = 8'h08;
            5'h0B:   v = 8'h04;
            5'h0A:   v = 8'h02;
            5'h0F:   v = 8'h01;
            default: v = '0;
        endcase
        return v;
    endfunction

    assign accept    = (state_q == S_IDLE) && bus.start;
    assign opv       = decode(opc_d);
    assign muldiv    = opv[3] | opv[0];
    assign unary     = opv[5] | opv[4];
    assign wait_last = ({1'b0, cnt_q} + 5'd1) >= 5'(MULDIV_WAIT);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            opc_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        opc_d = opc_q;
        ra_d  = ra_q;
        rb_d  = rb_q;
        rc_d  = rc_q;
        if (accept) begin
            opc_d = bus.opcode;
            ra_d  = bus.ra;
            rb_d  = bus.rb;
            rc_d  = bus.rc;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.start) state_d = (opv != '0) ? S_T3 : S_ERR;
            S_T3:   state_d = S_T4;
            S_T4:   state_d = (muldiv && MULDIV_WAIT != 0) ? S_WAIT : S_T5;
            S_WAIT: if (wait_last) state_d = S_T5;
            S_T5:   state_d = muldiv ? S_T6 : S_DONE;
            S_T6:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            S_ERR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cnt_d = (state_q == S_WAIT && state_d == S_WAIT) ? cnt_q + 4'd1 : '0;
    end

    always_comb begin
        out_d      = '0;
        out_d.busy = (state_d != S_IDLE);
        unique case (state_d)
            S_T3: begin
                out_d.sel  = rb_d;
                out_d.rout = 1'b1;
                out_d.yin  = 1'b1;
            end
            S_T4, S_WAIT: begin
                out_d.sel  = unary ? rb_d : rc_d;
                out_d.rout = 1'b1;
                out_d.op   = opv;
                out_d.zin  = 1'b1;
            end
            S_T5: begin
                out_d.zlo = 1'b1;
                if (muldiv) begin
                    out_d.loin = 1'b1;
                end else begin
                    out_d.sel = ra_d;
                    out_d.rin = 1'b1;
                end
            end
            S_T6: begin
                out_d.zhi  = 1'b1;
                out_d.hiin = 1'b1;
            end
            S_DONE:  out_d.done = 1'b1;
            S_ERR:   out_d.err  = 1'b1;
            default: out_d.busy = 1'b0;
        endcase
    end

    assign bus.reg_sel = out_q.sel;
    assign bus.Rout    = out_q.rout;
    assign bus.Rin     = out_q.rin;
    assign bus.Yin     = out_q.yin;
    assign bus.Zin     = out_q.zin;
    assign bus.ZLoout  = out_q.zlo;
    assign bus.ZHiout  = out_q.zhi;
    assign bus.LOin    = out_q.loin;
    assign bus.HIin    = out_q.hiin;
    assign bus.AND     = out_q.op[7];
    assign bus.OR      = out_q.op[6];
    assign bus.NEG     = out_q.op[5];
    assign bus.NOT     = out_q.op[4];
    assign bus.MUL     = out_q.op[3];
    assign bus.ROL     = out_q.op[2];
    assign bus.ROR     = out_q.op[1];
    assign bus.DIV     = out_q.op[0];
    assign bus.busy    = out_q.busy;
    assign bus.done    = out_q.done;
    assign bus.err     = out_q.err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: per-cycle reference schedule plus directed literal checks.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_alu_sequencer;

    localparam int W = 2;

    typedef struct packed {
        logic [3:0] sel;
        logic       rout;
        logic       rin;
        logic       yin;
        logic       zin;
        logic       zlo;
        logic       zhi;
        logic       loin;
        logic       hiin;
        logic [7:0] op;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    logic clk;
    logic clr;
    int   n_tests;
    int   n_fail;

    alu_sequencer_if bif ();

    alu_sequencer #(.MULDIV_WAIT(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bif)
    );

    exp_t dut_v;
    assign dut_v = {bif.reg_sel, bif.Rout, bif.Rin, bif.Yin, bif.Zin,
                    bif.ZLoout, bif.ZHiout, bif.LOin, bif.HIin,
                    bif.AND, bif.OR, bif.NEG, bif.NOT,
                    bif.MUL, bif.ROL, bif.ROR, bif.DIV,
                    bif.busy, bif.done, bif.err};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the op line an opcode selects, in AND..DIV order
    function automatic logic [7:0] op_line(input logic [4:0] opc);
        case (opc)
            5'h08:   return 8'b1000_0000;
            5'h09:   return 8'b0100_0000;
            5'h10:   return 8'b0010_0000;
            5'h11:   return 8'b0001_0000;
            5'h0E:   return 8'b0000_1000;
            5'h0B:   return 8'b0000_0100;
            5'h0A:   return 8'b0000_0010;
            5'h0F:   return 8'b0000_0001;
            default: return 8'b0;
        endcase
    endfunction

    exp_t q[$];
    exp_t cur;

    task automatic push_seq(input logic [4:0] opc, input logic [3:0] a,
                            input logic [3:0] b, input logic [3:0] c);
        exp_t e;
        logic [7:0] ol;
        bit md;
        bit un;
        ol = op_line(opc);
        md = (opc == 5'h0E) || (opc == 5'h0F);
        un = (opc == 5'h10) || (opc == 5'h11);
        if (ol == 8'b0) begin
            e = '0; e.busy = 1; e.err = 1;
            q.push_back(e);
            return;
        end
        e = '0; e.busy = 1; e.sel = b; e.rout = 1; e.yin = 1;
        q.push_back(e);
        for (int i = 0; i < 1 + (md ? W : 0); i++) begin
            e = '0; e.busy = 1; e.sel = un ? b : c;
            e.rout = 1; e.op = ol; e.zin = 1;
            q.push_back(e);
        end
        if (md) begin
            e = '0; e.busy = 1; e.zlo = 1; e.loin = 1;
            q.push_back(e);
            e = '0; e.busy = 1; e.zhi = 1; e.hiin = 1;
            q.push_back(e);
        end else begin
            e = '0; e.busy = 1; e.sel = a; e.zlo = 1; e.rin = 1;
            q.push_back(e);
        end
        e = '0; e.busy = 1; e.done = 1;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        if (clr && !cur.busy && bif.start)
            push_seq(bif.opcode, bif.ra, bif.rb, bif.rc);
    end

    always @(negedge clk) begin
        if (!clr) begin
            q.delete();
            cur = '0;
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else begin
            cur = '0;
        end
        check("cycle", 32'(dut_v), 32'(cur));
    end

    exp_t snap [0:16];
    int   lat;
    int   ndone;

    task automatic run(input logic [4:0] opc, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] c,
                       input bit spam);
        @(posedge clk); #1;
        bif.opcode = opc;
        bif.ra     = a;
        bif.rb     = b;
        bif.rc     = c;
        bif.start  = 1'b1;
        lat   = -1;
        ndone = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            snap[k] = dut_v;
            if (dut_v.done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
            if (!spam || lat >= 0) begin
                bif.start = 1'b0;
            end else begin
                bif.opcode = k[0] ? 5'h1F : 5'h08;
                bif.ra     = 4'(k);
                bif.rb     = 4'(k + 1);
                bif.rc     = 4'(k + 2);
            end
        end
    endtask

    initial begin
        int nmul;
        int nrin;
        int nwr;
        n_tests   = 0;
        n_fail    = 0;
        cur       = '0;
        bif.start = 1'b0;
        bif.opcode = '0;
        bif.ra    = '0;
        bif.rb    = '0;
        bif.rc    = '0;
        clr       = 1'b1;
        #1 clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(bif.busy), 32'd0);
        check("reset_outs", 32'(dut_v), 32'd0);
        clr = 1'b1;

        // AND r3 = r1 & r2
        run(5'h08, 4'd3, 4'd1, 4'd2, 1'b0);
        check("and_t3", {snap[1].sel, snap[1].rout, snap[1].yin}, {26'd0, 4'd1, 2'b11});
        check("and_t4_sel", 32'(snap[2].sel), 32'd2);
        check("and_t4_op", {snap[2].op, snap[2].zin}, {23'd0, 8'h80, 1'b1});
        check("and_t5", {snap[3].sel, snap[3].zlo, snap[3].rin}, {26'd0, 4'd3, 2'b11});
        check("and_lat", lat, 32'd4);

        // MUL with two settle cycles
        run(5'h0E, 4'd4, 4'd5, 4'd6, 1'b0);
        nmul = 0;
        nrin = 0;
        for (int k = 1; k <= 16; k++) begin
            if (snap[k].op[3] && snap[k].zin) nmul++;
            if (snap[k].rin) nrin++;
        end
        check("mul_hold", nmul, 32'd3);
        check("mul_no_rin", nrin, 32'd0);
        check("mul_lo", {snap[5].loin, snap[5].zlo}, 32'd3);
        check("mul_hi", {snap[6].hiin, snap[6].zhi}, 32'd3);
        check("mul_lat", lat, 32'd7);

        // NEG r6 = -r5
        run(5'h10, 4'd6, 4'd5, 4'd9, 1'b0);
        check("neg_t4_sel", 32'(snap[2].sel), 32'd5);
        check("neg_only", 32'(snap[2].op), 32'h20);
        check("neg_wb", {snap[3].sel, snap[3].rin}, {27'd0, 4'd6, 1'b1});
        check("neg_lat", lat, 32'd4);

        // Illegal opcode, then OR
        run(5'h1F, 4'd1, 4'd2, 4'd3, 1'b0);
        nwr = 0;
        for (int k = 1; k <= 16; k++)
            if (snap[k].rin || snap[k].loin || snap[k].hiin || snap[k].zin) nwr++;
        check("ill_err", {snap[1].err, snap[1].busy}, 32'd3);
        check("ill_no_wr", nwr, 32'd0);
        check("ill_idle", 32'(snap[2].busy), 32'd0);
        check("ill_no_done", lat, 32'hFFFF_FFFF);
        run(5'h09, 4'd7, 4'd8, 4'd10, 1'b0);
        check("or_op", 32'(snap[2].op), 32'h40);
        check("or_lat", lat, 32'd4);

        // DIV with start held high throughout
        run(5'h0F, 4'd7, 4'd8, 4'd9, 1'b1);
        check("div_sel", 32'(snap[2].sel), 32'd9);
        check("div_op", 32'(snap[4].op), 32'h01);
        check("div_ndone", ndone, 32'd1);
        check("div_lat", lat, 32'd7);

        // Reset during T4 of AND
        @(posedge clk); #1;
        bif.opcode = 5'h08;
        bif.ra     = 4'd3;
        bif.rb     = 4'd1;
        bif.rc     = 4'd2;
        bif.start  = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_and", 32'(bif.AND), 32'd1);
        #2 clr = 1'b0;
        #1;
        check("rst_async", 32'(dut_v), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bif.busy), 32'd0);
        clr = 1'b1;
        run(5'h0B, 4'd2, 4'd4, 4'd1, 1'b0);
        check("rol_after_rst", 32'(snap[2].op), 32'h04);
        check("rol_lat", lat, 32'd4);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
